// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ctl,
    input  logic [31:0] s,
    input  logic [31:0] t,
    input  logic        pause_i,
    output logic [31:0] res,
    output logic        busy,
    output logic        pause_o
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, is_div_q, is_div_d;

    logic        is_signed;
    logic [31:0] s_mag, t_mag;
    logic [32:0] mul_sum, div_diff;

    assign is_signed = (ctl == OpMult) || (ctl == OpDiv);
    assign s_mag     = (is_signed && s[31]) ? (~s + 32'd1) : s;
    assign t_mag     = (is_signed && t[31]) ? (~t + 32'd1) : t;
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvsr_q} : 33'd0);
    // Remainder shifted left by one is 33 bits wide; borrow in bit 32 means "restore".
    assign div_diff  = acc_q[63:31] - {1'b0, dvsr_q};

    assign busy    = (state_q != StIdle);
    assign pause_o = busy && (ctl >= OpMult) && (ctl <= OpMtlo);
    assign res     = (ctl == OpMfhi) ? hi_q : (ctl == OpMflo) ? lo_q : 32'd0;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_d      = acc_q;
        dvsr_d     = dvsr_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        is_div_d   = is_div_q;
        unique case (state_q)
            StIdle: begin
                if (!pause_i) begin
                    case (ctl)
                        OpMult, OpMultu: begin
                            acc_d      = {32'd0, t_mag};
                            dvsr_d     = s_mag;
                            neg_quot_d = is_signed && (s[31] ^ t[31]);
                            neg_rem_d  = 1'b0;
                            is_div_d   = 1'b0;
                            cnt_d      = 6'd0;
                            state_d    = StMul;
                        end
                        OpDiv, OpDivu: begin
                            acc_d      = {32'd0, s_mag};
                            dvsr_d     = t_mag;
                            // Divide by zero keeps the all-ones quotient unsigned.
                            neg_quot_d = is_signed && (s[31] ^ t[31]) && (t != 32'd0);
                            neg_rem_d  = is_signed && s[31];
                            is_div_d   = 1'b1;
                            cnt_d      = 6'd0;
                            state_d    = StDiv;
                        end
                        OpMthi:  hi_d = s;
                        OpMtlo:  lo_d = s;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[31:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = StFix;
            end
            StDiv: begin
                if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                else               acc_d = {acc_q[62:0], 1'b0};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    lo_d = neg_quot_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                    hi_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                end else begin
                    {hi_d, lo_d} = neg_quot_q ? (~acc_q + 64'd1) : acc_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            acc_q      <= 64'd0;
            dvsr_q     <= 32'd0;
            cnt_q      <= 6'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_q      <= acc_d;
            dvsr_q     <= dvsr_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            is_div_q   <= is_div_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: timing, signed/unsigned results, moves, stalls.
module tb_muldiv_unit;

    localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  ctl = NOP;
    logic [31:0] s = 32'd0, t = 32'd0;
    logic        pause_i = 1'b0;
    logic [31:0] res;
    logic        busy, pause_o;

    int total = 0;
    int bad   = 0;

    muldiv_unit dut (
        .clk     (clk),
        .rst     (rst),
        .ctl     (ctl),
        .s       (s),
        .t       (t),
        .pause_i (pause_i),
        .res     (res),
        .busy    (busy),
        .pause_o (pause_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one edge, then return ctl to NOP (now in cycle 1).
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ctl = op; s = a; t = b;
        step();
        ctl = NOP; s = 32'd0; t = 32'd0;
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        ctl = MFHI; #1; h = res;
        ctl = MFLO; #1; l = res;
        ctl = NOP;  #1;
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        #2;
        ctl = MULT; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (pause_o !== 1'b0) begin bad++; $display("FAIL reset_pause: got %b want 0", pause_o); end
        read_hilo(h, l);
        total++; if (h !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", h); end
        total++; if (l !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", l); end
        total++; if (res !== 32'd0) begin bad++; $display("FAIL reset_res_nop: got %h want 0", res); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] h, l;
        int n;
        start_op(MTHI, 32'hDEAD_BEEF, 32'd0);
        start_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midop_busy_before: got %b want 1", busy); end
        rst = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midop_busy_after: got %b want 0", busy); end
        read_hilo(h, l);
        total++; if (h !== 32'd0) begin bad++; $display("FAIL midop_hi: got %h want 0", h); end
        total++; if (l !== 32'd0) begin bad++; $display("FAIL midop_lo: got %h want 0", l); end
        rst = 1'b1;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midop_idle: got %b want 0", busy); end
        start_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        total++; if (n !== 33) begin bad++; $display("FAIL multu_busy_cycles: got %0d want 33", n); end
        read_hilo(h, l);
        total++; if (h !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", h); end
        total++; if (l !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", l); end
    endtask

    task automatic test_signed_mult_stall();
        int stalls = 0;
        start_op(MULT, 32'hFFFF_FFF9, 32'd3);
        total++; if (pause_o !== 1'b0) begin bad++; $display("FAIL mult_nop_nostall: got %b want 0", pause_o); end
        ctl = MFLO; #1;
        while (pause_o && stalls < 50) begin
            step();
            stalls++;
        end
        total++; if (stalls !== 33) begin bad++; $display("FAIL mult_stall_cycles: got %0d want 33", stalls); end
        total++; if (res !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_mflo: got %h want ffffffeb", res); end
        ctl = MFHI; #1;
        total++; if (res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_mfhi: got %h want ffffffff", res); end
        ctl = NOP; #1;
    endtask

    task automatic test_signed_div();
        logic [31:0] h, l;
        int n;
        start_op(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        total++; if (n !== 33) begin bad++; $display("FAIL div_busy_cycles: got %0d want 33", n); end
        read_hilo(h, l);
        total++; if (l !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", l); end
        total++; if (h !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", h); end
        start_op(DIVU, 32'd100, 32'd7);
        ctl = MTHI; s = 32'hBAD0_BAD0; #1;
        total++; if (pause_o !== 1'b1) begin bad++; $display("FAIL mthi_busy_stall: got %b want 1", pause_o); end
        step();
        ctl = NOP; s = 32'd0; #1;
        wait_idle(n);
        read_hilo(h, l);
        total++; if (l !== 32'd14) begin bad++; $display("FAIL divu_lo: got %h want 0000000e", l); end
        total++; if (h !== 32'd2) begin bad++; $display("FAIL divu_hi: got %h want 00000002", h); end
    endtask

    task automatic test_div_edge();
        logic [31:0] h, l;
        int n;
        start_op(DIVU, 32'd5, 32'd0);
        wait_idle(n);
        total++; if (n !== 33) begin bad++; $display("FAIL divz_busy_cycles: got %0d want 33", n); end
        read_hilo(h, l);
        total++; if (l !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divuz_lo: got %h want ffffffff", l); end
        total++; if (h !== 32'd5) begin bad++; $display("FAIL divuz_hi: got %h want 00000005", h); end
        start_op(DIV, 32'hFFFF_FFFB, 32'd0);
        wait_idle(n);
        read_hilo(h, l);
        total++; if (l !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_lo: got %h want ffffffff", l); end
        total++; if (h !== 32'hFFFF_FFFB) begin bad++; $display("FAIL divz_hi: got %h want fffffffb", h); end
        start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        read_hilo(h, l);
        total++; if (l !== 32'h8000_0000) begin bad++; $display("FAIL divovf_lo: got %h want 80000000", l); end
        total++; if (h !== 32'd0) begin bad++; $display("FAIL divovf_hi: got %h want 00000000", h); end
    endtask

    task automatic test_moves_pause();
        logic [31:0] h, l;
        start_op(MTHI, 32'h1234_5678, 32'd0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_nobusy: got %b want 0", busy); end
        start_op(MTLO, 32'hCAFE_0000, 32'd0);
        read_hilo(h, l);
        total++; if (h !== 32'h1234_5678) begin bad++; $display("FAIL mthi_val: got %h want 12345678", h); end
        total++; if (l !== 32'hCAFE_0000) begin bad++; $display("FAIL mtlo_val: got %h want cafe0000", l); end
        pause_i = 1'b1;
        ctl = MTLO; s = 32'h55AA_55AA;
        for (int i = 0; i < 3; i++) begin
            step();
            ctl = MFLO; #1;
            total++; if (res !== 32'hCAFE_0000) begin bad++; $display("FAIL mtlo_paused%0d: got %h want cafe0000", i, res); end
            ctl = MTLO; #1;
        end
        pause_i = 1'b0;
        step();
        ctl = MFLO; #1;
        total++; if (res !== 32'h55AA_55AA) begin bad++; $display("FAIL mtlo_released: got %h want 55aa55aa", res); end
        ctl = NOP; s = 32'd0; #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l;
        int stalls = 0;
        int n;
        start_op(DIVU, 32'd1000, 32'd3);
        ctl = MULTU; s = 32'h1234_5678; t = 32'h0000_0010; #1;
        while (pause_o && stalls < 50) begin
            step();
            stalls++;
        end
        total++; if (stalls !== 33) begin bad++; $display("FAIL b2b_stall_cycles: got %0d want 33", stalls); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap: got %b want 0", busy); end
        step();
        ctl = NOP; s = 32'd0; t = 32'd0; #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", busy); end
        read_hilo(h, l);
        total++; if (l !== 32'd333) begin bad++; $display("FAIL b2b_divu_lo: got %h want 0000014d", l); end
        total++; if (h !== 32'd1) begin bad++; $display("FAIL b2b_divu_hi: got %h want 00000001", h); end
        wait_idle(n);
        total++; if (n !== 33) begin bad++; $display("FAIL b2b_mul_cycles: got %0d want 33", n); end
        read_hilo(h, l);
        total++; if (h !== 32'h0000_0001) begin bad++; $display("FAIL b2b_multu_hi: got %h want 00000001", h); end
        total++; if (l !== 32'h2345_6780) begin bad++; $display("FAIL b2b_multu_lo: got %h want 23456780", l); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_signed_mult_stall();
        test_signed_div();
        test_div_edge();
        test_moves_pause();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
